// File: rtl/ls166.sv
// 74LS166 8-bit parallel-in/serial-out shift register with asynchronous clear.
// Optional build macro LS166_TAP_EN exposes the full register as q_tap.
module ls166 (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       sh_ld_n,
    input  logic       clk_inh,
    input  logic       ser,
    input  logic [7:0] d,
    output logic       qh
`ifdef LS166_TAP_EN
    ,
    output logic [7:0] q_tap
`endif
);

    logic [7:0] q_r;
    logic [7:0] q_next_s;

    // Next-state select: inhibit blocks both load and shift; stage A takes ser on shift
    always_comb begin
        q_next_s = q_r;
        if (clk_inh == 1'b1) begin
            q_next_s = q_r;
        end else if (sh_ld_n == 1'b0) begin
            q_next_s = d;
        end else begin
            q_next_s = {q_r[6:0], ser};
        end
    end

    // Register stages A..H; clear acts immediately regardless of clk
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= 8'h00;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign qh = q_r[7];

`ifdef LS166_TAP_EN
    assign q_tap = q_r;
`endif

endmodule

// File: tb/tb_ls166.sv
// Scoreboard bench for ls166: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against qh (and q_tap when built with it).
module tb_ls166;

    logic       clk;
    logic       clr_n;
    logic       sh_ld_n;
    logic       clk_inh;
    logic       ser;
    logic [7:0] d;
    logic       qh;
`ifdef LS166_TAP_EN
    logic [7:0] q_tap;
`endif

    typedef struct {
        logic       qh;
        logic [7:0] tap;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    ls166 dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .sh_ld_n (sh_ld_n),
        .clk_inh (clk_inh),
        .ser     (ser),
        .d       (d),
        .qh      (qh)
`ifdef LS166_TAP_EN
        ,
        .q_tap   (q_tap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation is checked per falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (qh !== e.qh) begin
                bad++;
                $display("FAIL %s: qh got %b expected %b", e.name, qh, e.qh);
            end
`ifdef LS166_TAP_EN
            total++;
            if (q_tap !== e.tap) begin
                bad++;
                $display("FAIL %s: q_tap got %h expected %h", e.name, q_tap, e.tap);
            end
`endif
        end
    end

    task automatic push_exp(input logic eq, input logic [7:0] et, input string nm);
        exp_t e;
        e.qh   = eq;
        e.tap  = et;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Apply inputs, take one rising edge, queue the expected post-edge state
    task automatic step(input logic c, input logic sl, input logic inh, input logic s,
                        input logic [7:0] dv, input logic eq, input logic [7:0] et,
                        input string nm);
        clr_n   = c;
        sh_ld_n = sl;
        clk_inh = inh;
        ser     = s;
        d       = dv;
        @(posedge clk);
        #1;
        push_exp(eq, et, nm);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] a5_tap [0:8];
    logic [7:0] fill_tap [0:8];
    logic [7:0] b3c_tap [0:7];
    logic [7:0] bc3_tap [0:7];

    initial begin
        total = 0;
        bad   = 0;
        a5_tap   = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
        fill_tap = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        b3c_tap  = '{8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};
        bc3_tap  = '{8'hC3, 8'h86, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80};

        // Reset held with load/shift activity
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, "reset_load");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, "reset_shift");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, "reset_inh");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, "release_shift");

        // Load A5 and serialise
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, a5_tap[0], "a5_load");
        for (int i = 1; i <= 8; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, a5_tap[i][7], a5_tap[i], $sformatf("a5_shift%0d", i));

        // Inhibit blocks loads and shifts
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 8'h80, "inh_load80");
        for (int i = 0; i < 5; i++)
            step(1'b1, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h80,
                 $sformatf("inh_hold%0d", i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "inh_release_shift");

        // Serial fill with ones after clear
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, "fill_clear");
        for (int i = 1; i <= 8; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, fill_tap[i][7], fill_tap[i], $sformatf("fill_shift%0d", i));
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, "fill_stay");

        // Async clear mid-byte
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, "ac_load");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, "ac_shift1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFC, "ac_shift2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hF8, "ac_shift3");
        clk_inh = 1'b1;
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        push_exp(1'b0, 8'h00, "ac_async");
        @(negedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, "ac_held_load");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, "ac_held_shift");

        // Back-to-back bytes 3C then C3
        for (int i = 0; i < 8; i++)
            step(1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'h3C, b3c_tap[i][7], b3c_tap[i],
                 $sformatf("b2b_3c_%0d", i));
        for (int i = 0; i < 8; i++)
            step(1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'hC3, bc3_tap[i][7], bc3_tap[i],
                 $sformatf("b2b_c3_%0d", i));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ls166.md
# ls166

Behavioural SystemVerilog model of the 74LS166 8-bit parallel-in/serial-out shift register with asynchronous clear, for the TTL chip library used by the arcade board recreations. It converts a parallel byte into a serial bit stream, for example graphics ROM data into per-pixel bits on the video path. It is the transmitting end that turns latched parallel data into a serial stream for downstream gating logic.

## Interface
Parameters:
- none; width is fixed at 8 to match the physical part.

Ports:
- clk  input  1  the single clock; maps to chip pin 7 (CLK); all state changes occur on its rising edge.
- clr_n  input  1  chip pin 9 (CLR); asynchronous, active-low reset.
- sh_ld_n  input  1  chip pin 15 (SH/LD); 1 = shift, 0 = parallel load.
- clk_inh  input  1  chip pin 6 (CLK INH); 1 = hold, 0 = clock enabled.
- ser  input  1  chip pin 1 (SER); serial input into stage A.
- d  input  8  parallel inputs A..H, with d[0]=A (pin 2) and d[7]=H (pin 14).
- qh  output  1  chip pin 13 (QH); last stage (stage H) of the register.

## Operation
- Internal state: 8-bit register q, with q[0]=stage A and q[7]=stage H. qh = q[7] continuously.
- Clear: while clr_n=0, q=8'h00 and qh=0. Clear takes effect immediately, independent of clk. It overrides load, shift and inhibit.
- Priority on each rising clk edge while clr_n=1:
  1. clk_inh=1: hold. q is unchanged, and a parallel load is also blocked.
  2. clk_inh=0, sh_ld_n=0: synchronous load, q <= d.
  3. clk_inh=0, sh_ld_n=1: shift toward H, q <= {q[6:0], ser}. Stage A takes ser and the old q[7] is discarded.
- There is no other state and no FSM beyond the three modes above. There is no internal counter: the caller sequences eight shifts per byte.
- Inputs are assumed synchronous to clk. The model adds no synchronisers.

## Timing
- Reset values: q=8'h00, qh=0.
- Load latency is one edge: qh equals d[7] immediately after the loading edge.
- Shift latency: the bit loaded into stage k (d[k]) reaches qh after 7-k shift edges. ser presented at an edge reaches qh after 8 edges.
- Back-to-back load then shift is legal on consecutive edges.
- Continuous shifting with ser=0 empties the register to 0 after 8 edges. There is no wrap-around and q[7] is not recirculated.
- clk_inh may toggle on any cycle. An inhibited edge is a pure no-op. Toggling clk_inh never glitches qh, because qh is registered.
- Clear asserted mid-byte aborts the byte; partial data is lost. After clr_n deasserts, the first rising edge is a normal edge: it loads or shifts per sh_ld_n and clk_inh.
- clr_n deasserting on the same edge as sh_ld_n=0: the load occurs on that edge only if clr_n was already high at the edge. A simultaneous release is treated as still cleared.

## Configuration
- Macro LS166_TAP_EN.
- Defined: adds output port q_tap [7:0], which mirrors internal q with identical reset and timing. Bench and debug builds use it to check every stage.
- Undefined: q_tap does not exist, and the port list is exactly as in Interface. Functional behaviour of qh is identical in both builds.

## Test plan
- Reset: hold clr_n=0 with arbitrary inputs and clocks running -> qh=0 (q_tap=8'h00 if enabled). Release and apply one shift edge with ser=1 -> q_tap=8'h01, qh=0.
- Load and serialise: load d=8'hA5, then 7 shift edges with ser=0 -> qh sequence is 1,0,1,0,0,1,0,1 (H down to A). On the 8th edge qh=0 (the bit from ser).
- Inhibit: load 8'h80 (qh=1). Hold clk_inh=1 for 5 edges with sh_ld_n toggling and d=8'h00 -> qh stays 1 and q_tap stays 8'h80. Drop clk_inh and shift once -> qh=0.
- Serial fill: after clear, 8 shift edges with ser=1 -> q_tap=8'hFF and qh=1 from the 8th edge onward.
- Async clear mid-byte: load 8'hFF, shift 3 times, then assert clr_n between clk edges -> qh falls to 0 before the next edge and stays 0 while clr_n=0.
- Back-to-back bytes: load 8'h3C, 7 shifts, then load 8'hC3 on the next edge, 7 shifts -> qh gives the 16-bit stream 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1 with no gap.
